// File: rtl/rgb_frame_fetch_if.sv
// rgb_frame_fetch_if: raster pixel stream, valid/ready handshake.
// master = pixel source, slave = display/output path.
interface rgb_frame_fetch_if;
  logic       pixel_valid;
  logic       pixel_ready;
  logic [7:0] pixel_R;
  logic [7:0] pixel_G;
  logic [7:0] pixel_B;
  logic       pixel_eol;
  logic       pixel_eof;

  modport master (
    output pixel_valid,
    output pixel_R,
    output pixel_G,
    output pixel_B,
    output pixel_eol,
    output pixel_eof,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid,
    input  pixel_R,
    input  pixel_G,
    input  pixel_B,
    input  pixel_eol,
    input  pixel_eof,
    output pixel_ready
  );
endinterface

// File: rtl/rgb_frame_fetch.sv
// rgb_frame_fetch: reads packed RGB words from SRAM (3 words per
// 2 pixels), unpacks them and streams pixels through a FWFT FIFO.
module rgb_frame_fetch #(
  parameter logic [17:0] RGB_START  = 18'd146944,
  parameter int          IMG_WIDTH  = 320,
  parameter int          IMG_HEIGHT = 240,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  output logic        Stop,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  rgb_frame_fetch_if.master pix
);

  localparam int GROUPS = IMG_WIDTH * IMG_HEIGHT / 2;
  localparam int GW     = $clog2(GROUPS + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int XW     = $clog2(IMG_WIDTH);
  localparam int YW     = $clog2(IMG_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RD0, S_RD1, S_RD2, S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [17:0]     waddr_q, waddr_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [17:0]     addr_q, addr_d;
  logic            stop_q, stop_d;
  logic            clr;

  logic [2:0]      tv_q;
  logic [1:0]      ts_q [3];
  logic            rd_now;
  logic [1:0]      slot_now;

  logic [7:0]      r0_q, g0_q, r1_q;
  logic            push, pop;
  logic [23:0]     push_pix;

  logic [23:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q, infl_q;
  logic [CW:0]     used;
  logic            free_ok;
  logic            issue;
  logic            valid;
  logic [23:0]     head;

  logic [XW-1:0]   col_q;
  logic [YW-1:0]   row_q;
  logic            last_col;

  assign SRAM_write_data = 16'd0;
  assign SRAM_we_n       = 1'b1;
  assign SRAM_address    = addr_q;
  assign Stop            = stop_q;

  // Credit: FIFO entries plus pixels already promised by issued groups.
  assign used    = {1'b0, cnt_q} + {1'b0, infl_q};
  assign free_ok = used <= (CW+1)'(FIFO_DEPTH - 2);
  assign issue   = (state_d == S_RD0);

  // Next-state and datapath decode of the fetch sequencer.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    grp_d   = grp_q;
    addr_d  = addr_q;
    stop_d  = stop_q;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          stop_d  = 1'b0;
          waddr_d = RGB_START;
          grp_d   = GW'(GROUPS);
          clr     = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (grp_q == '0) state_d = S_DRAIN;
        else if (free_ok) state_d = S_RD0;
      end
      S_RD0: begin
        addr_d  = waddr_q;
        state_d = S_RD1;
      end
      S_RD1: begin
        addr_d  = waddr_q + 18'd1;
        state_d = S_RD2;
      end
      S_RD2: begin
        addr_d = waddr_q + 18'd2;
        grp_d  = grp_q - GW'(1);
        // The last group leaves word_addr alone so it never wraps.
        if (grp_q > GW'(1)) waddr_d = waddr_q + 18'd3;
        if (grp_q > GW'(1) && free_ok) state_d = S_RD0;
        else state_d = S_HOLD;
      end
      S_DRAIN: begin
        if (infl_q == '0 && cnt_q == '0) begin
          stop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers and the registered SRAM address.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      grp_q   <= '0;
      addr_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      grp_q   <= grp_d;
      addr_q  <= addr_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    rd_now   = 1'b0;
    slot_now = 2'd0;
    unique case (1'b1)
      state_q == S_RD0: begin rd_now = 1'b1; slot_now = 2'd0; end
      state_q == S_RD1: begin rd_now = 1'b1; slot_now = 2'd1; end
      state_q == S_RD2: begin rd_now = 1'b1; slot_now = 2'd2; end
      default: ;
    endcase
  end

  // Slot tags travel with each read so data lands 3 edges later.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tv_q    <= '0;
      ts_q[0] <= '0;
      ts_q[1] <= '0;
      ts_q[2] <= '0;
    end else begin
      tv_q    <= {tv_q[1:0], rd_now};
      ts_q[0] <= slot_now;
      ts_q[1] <= ts_q[0];
      ts_q[2] <= ts_q[1];
    end
  end

  assign push = tv_q[2] && (ts_q[2] != 2'd0);
  assign pop  = valid && pix.pixel_ready;
  assign push_pix = (ts_q[2] == 2'd1)
    ? {r0_q, g0_q, SRAM_read_data[15:8]}
    : {r1_q, SRAM_read_data};

  // Holding registers for components split across words.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r0_q <= '0;
      g0_q <= '0;
      r1_q <= '0;
    end else if (tv_q[2]) begin
      if (ts_q[2] == 2'd0) begin
        r0_q <= SRAM_read_data[15:8];
        g0_q <= SRAM_read_data[7:0];
      end
      if (ts_q[2] == 2'd1) r1_q <= SRAM_read_data[7:0];
    end
  end

  // FIFO storage; contents are don't-care while not counted.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wp_q] <= push_pix;
  end

  // FIFO pointers, occupancy and outstanding pixel credit.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      infl_q <= infl_q + (issue ? CW'(2) : CW'(0)) - CW'(push);
    end
  end

  assign valid    = (cnt_q != '0);
  assign head     = mem_q[rp_q];
  assign last_col = (col_q == XW'(IMG_WIDTH - 1));

  // Raster position of the FIFO head.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pop) begin
      if (last_col) begin
        col_q <= '0;
        if (row_q == YW'(IMG_HEIGHT - 1)) row_q <= '0;
        else row_q <= row_q + YW'(1);
      end else begin
        col_q <= col_q + XW'(1);
      end
    end
  end

  assign pix.pixel_valid = valid;
  assign pix.pixel_R     = valid ? head[23:16] : 8'd0;
  assign pix.pixel_G     = valid ? head[15:8]  : 8'd0;
  assign pix.pixel_B     = valid ? head[7:0]   : 8'd0;
  assign pix.pixel_eol   = valid && last_col;
  assign pix.pixel_eof   = valid && last_col &&
                           (row_q == YW'(IMG_HEIGHT - 1));

endmodule
